// File: rtl/posit_decode_stream.sv
// Two-stage streaming posit decoder: sign, regime/exponent scale, mantissa, zero/NaR flags.
// Define POSIT_DECODE_STATS_EN to add saturating cnt_zero/cnt_inf handshake counters.
module posit_decode_stream #(
    parameter int N  = 32,
    parameter int es = 2,
    parameter int Bs = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_s,
    output logic [Bs+es:0]    out_scale,
    output logic [N-es:0]     out_mant,
    output logic              out_zero,
    output logic              out_inf
`ifdef POSIT_DECODE_STATS_EN
    ,
    output logic [31:0]       cnt_zero,
    output logic [31:0]       cnt_inf
`endif
);

    logic          va_q, va_d, vb_q, vb_d;
    logic          a_s_q, a_s_d, a_zero_q, a_zero_d, a_inf_q, a_inf_d, a_r0_q, a_r0_d;
    logic [Bs-1:0] a_run_q, a_run_d;
    logic [N-2:0]  a_body_q, a_body_d;
    logic          b_s_q, b_s_d, b_zero_q, b_zero_d, b_inf_q, b_inf_d;
    logic [Bs+es:0] b_scale_q, b_scale_d;
    logic [N-es:0] b_mant_q, b_mant_d;
    logic [31:0]   cnt_zero_q, cnt_zero_d, cnt_inf_q, cnt_inf_d;

    logic          b_free, a_free, fire_out, run_stop;
    logic [N-1:0]  word, word_neg;
    logic [N-2:0]  body;
    logic [Bs:0]   shamt;
    logic [Bs:0]   k;
    logic [N-1:0]  tail;

    always_comb begin
        b_free   = ~vb_q | out_ready;
        a_free   = ~va_q | b_free;
        in_ready = ~reset & a_free;
        fire_out = vb_q & out_ready;

        // X on the input collapses to zero in simulation; synthesis sees a plain pass-through.
        word     = ((^in_data) === 1'bx) ? '0 : in_data;
        word_neg = -word;
        body     = word[N-1] ? word_neg[N-2:0] : word[N-2:0];

        va_d     = va_q;
        a_s_d    = a_s_q;
        a_zero_d = a_zero_q;
        a_inf_d  = a_inf_q;
        a_r0_d   = a_r0_q;
        a_run_d  = a_run_q;
        a_body_d = a_body_q;
        if (a_free) begin
            va_d = in_valid;
            if (in_valid) begin
                a_s_d    = word[N-1];
                a_zero_d = (word == '0);
                a_inf_d  = (word == {1'b1, {(N-1){1'b0}}});
                a_r0_d   = body[N-2];
                a_body_d = body;
                a_run_d  = '0;
                run_stop = 1'b0;
                for (int i = N-2; i >= 0; i--) begin
                    if (!run_stop) begin
                        if (body[i] == body[N-2]) a_run_d = a_run_d + Bs'(1);
                        else                      run_stop = 1'b1;
                    end
                end
            end
        end
        run_stop = 1'b0;

        // Drop the regime run and its terminator; what remains is exponent then fraction.
        shamt = {1'b0, a_run_q} + (Bs+1)'(1);
        tail  = {a_body_q, 1'b0} << shamt;
        k     = a_r0_q ? ({1'b0, a_run_q} - (Bs+1)'(1)) : -{1'b0, a_run_q};

        vb_d      = vb_q;
        b_s_d     = b_s_q;
        b_zero_d  = b_zero_q;
        b_inf_d   = b_inf_q;
        b_scale_d = b_scale_q;
        b_mant_d  = b_mant_q;
        if (b_free) begin
            vb_d = va_q;
            if (va_q) begin
                b_s_d    = a_s_q;
                b_zero_d = a_zero_q;
                b_inf_d  = a_inf_q;
                if (a_zero_q | a_inf_q) begin
                    b_scale_d = '0;
                    b_mant_d  = '0;
                end else begin
                    b_scale_d = {k, tail[N-1 -: es]};
                    b_mant_d  = {1'b1, tail[N-1-es:0]};
                end
            end
        end

        cnt_zero_d = cnt_zero_q;
        cnt_inf_d  = cnt_inf_q;
        if (fire_out && b_zero_q && (cnt_zero_q != '1)) cnt_zero_d = cnt_zero_q + 32'd1;
        if (fire_out && b_inf_q  && (cnt_inf_q  != '1)) cnt_inf_d  = cnt_inf_q  + 32'd1;
    end

    // NOTE: every flop here is updated with <= so all registers sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (reset) begin
            va_q       <= 1'b0;
            vb_q       <= 1'b0;
            a_s_q      <= 1'b0;
            a_zero_q   <= 1'b0;
            a_inf_q    <= 1'b0;
            a_r0_q     <= 1'b0;
            a_run_q    <= '0;
            a_body_q   <= '0;
            b_s_q      <= 1'b0;
            b_zero_q   <= 1'b0;
            b_inf_q    <= 1'b0;
            b_scale_q  <= '0;
            b_mant_q   <= '0;
            cnt_zero_q <= '0;
            cnt_inf_q  <= '0;
        end else begin
            va_q       <= va_d;
            vb_q       <= vb_d;
            a_s_q      <= a_s_d;
            a_zero_q   <= a_zero_d;
            a_inf_q    <= a_inf_d;
            a_r0_q     <= a_r0_d;
            a_run_q    <= a_run_d;
            a_body_q   <= a_body_d;
            b_s_q      <= b_s_d;
            b_zero_q   <= b_zero_d;
            b_inf_q    <= b_inf_d;
            b_scale_q  <= b_scale_d;
            b_mant_q   <= b_mant_d;
            cnt_zero_q <= cnt_zero_d;
            cnt_inf_q  <= cnt_inf_d;
        end
    end

    assign out_valid = vb_q;
    assign out_s     = b_s_q;
    assign out_scale = b_scale_q;
    assign out_mant  = b_mant_q;
    assign out_zero  = b_zero_q;
    assign out_inf   = b_inf_q;

`ifdef POSIT_DECODE_STATS_EN
    assign cnt_zero = cnt_zero_q;
    assign cnt_inf  = cnt_inf_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_zero_q, cnt_inf_q, cnt_zero_d, cnt_inf_d};
`endif

endmodule

// File: tb/tb_posit_decode_stream.sv
// Self-checking bench for posit_decode_stream: directed vectors, backpressure, reset flush, random traffic.
module tb_posit_decode_stream;
    localparam int N  = 32;
    localparam int ES = 2;
    localparam int BS = 5;

    logic              clk = 1'b0;
    logic              reset, in_valid, out_ready;
    logic [N-1:0]      in_data;
    logic              in_ready, out_valid, out_s, out_zero, out_inf;
    logic [BS+ES:0]    out_scale;
    logic [N-ES:0]     out_mant;
`ifdef POSIT_DECODE_STATS_EN
    logic [31:0]       cnt_zero, cnt_inf;
`endif

    always #5 clk = ~clk;

    posit_decode_stream #(.N(N), .es(ES), .Bs(BS)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_scale(out_scale),
        .out_mant(out_mant), .out_zero(out_zero), .out_inf(out_inf)
`ifdef POSIT_DECODE_STATS_EN
        , .cnt_zero(cnt_zero), .cnt_inf(cnt_inf)
`endif
    );

    typedef struct packed {
        logic        s;
        logic [7:0]  scale;
        logic [30:0] mant;
        logic        zero;
        logic        inf;
    } dec_t;

    int   checks = 0;
    int   failures = 0;
    dec_t exp_q[$];
    int   n_out = 0, n_zero = 0, n_inf = 0;
    bit   held = 0, saw_stall = 0, done = 0;
    dec_t held_v, obs_v, pop_v;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference decode straight from the posit definition using integer arithmetic.
    function automatic dec_t model(logic [31:0] w);
        dec_t r;
        logic [31:0] a;
        logic r0;
        int run, m, f, k, e;
        longint unsigned rem, frac;
        r = '0;
        r.s = w[31];
        if (w == 32'h0) r.zero = 1'b1;
        else if (w == 32'h8000_0000) r.inf = 1'b1;
        else begin
            a = w[31] ? -w : w;
            r0 = a[30];
            run = 0;
            for (int i = 30; i >= 0; i--) begin
                if (a[i] != r0) break;
                run++;
            end
            m = 30 - run;
            rem = (m > 0) ? ({32'd0, a} & ((64'd1 << m) - 64'd1)) : 64'd0;
            e = (m >= 2) ? int'(rem >> (m - 2)) : int'(rem << (2 - m));
            f = (m > 2) ? m - 2 : 0;
            frac = rem & ((64'd1 << f) - 64'd1);
            r.mant = 31'((64'd1 << 30) | (frac << (30 - f)));
            k = r0 ? run - 1 : -run;
            r.scale = 8'(k * 4 + e);
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 3))
            0: w = $urandom;
            1: w = $urandom >> $urandom_range(0, 31);
            2: w = ~($urandom >> $urandom_range(0, 31));
            default: case ($urandom_range(0, 5))
                0: w = 32'h0;
                1: w = 32'h8000_0000;
                2: w = 32'h7FFF_FFFF;
                3: w = 32'h0000_0001;
                4: w = 32'hFFFF_FFFF;
                default: w = 32'h8000_0001;
            endcase
        endcase
        if ($urandom_range(0, 1) == 1) w = -w;
        return w;
    endfunction

    // Scoreboard and hold-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held = 0;
            n_zero = 0;
            n_inf = 0;
        end else begin
            obs_v = {out_s, out_scale, out_mant, out_zero, out_inf};
            if (held) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'(obs_v), 64'(held_v));
            end
            if (in_valid && !in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 64'(1), 64'(0));
                else begin
                    pop_v = exp_q.pop_front();
                    check("decode", 64'(obs_v), 64'(pop_v));
                    n_out++;
                    if (pop_v.zero) n_zero++;
                    if (pop_v.inf) n_inf++;
                end
            end
            held = out_valid && !out_ready;
            held_v = obs_v;
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
    end

    task automatic send(logic [31:0] w);
        int t;
        bit acc;
        t = 0;
        acc = 0;
        in_valid = 1'b1;
        in_data = w;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic directed(string tag, logic [31:0] w, dec_t e);
        check({tag, "_ready"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        in_data = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        check({tag, "_lat2"}, 64'(out_valid), 64'(1));
        check(tag, 64'({out_s, out_scale, out_mant, out_zero, out_inf}), 64'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t;
        reset = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_outputs", 64'({out_s, out_scale, out_mant, out_zero, out_inf}), 64'(0));
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        directed("p_one",    32'h4000_0000, '{1'b0, 8'd0,   31'h4000_0000, 1'b0, 1'b0});
        directed("p_scale1", 32'h4800_0000, '{1'b0, 8'd1,   31'h4000_0000, 1'b0, 1'b0});
        directed("p_scale2", 32'h5000_0000, '{1'b0, 8'd2,   31'h4000_0000, 1'b0, 1'b0});
        directed("n_one",    32'hC000_0000, '{1'b1, 8'd0,   31'h4000_0000, 1'b0, 1'b0});
        directed("maxpos",   32'h7FFF_FFFF, '{1'b0, 8'd120, 31'h4000_0000, 1'b0, 1'b0});
        directed("minpos",   32'h0000_0001, '{1'b0, 8'h88,  31'h4000_0000, 1'b0, 1'b0});
        directed("zero",     32'h0000_0000, '{1'b0, 8'd0,   31'h0,         1'b1, 1'b0});
        directed("nar",      32'h8000_0000, '{1'b1, 8'd0,   31'h0,         1'b0, 1'b1});
        directed("p_frac",   32'h4C00_0000, '{1'b0, 8'd1,   31'h6000_0000, 1'b0, 1'b0});
        directed("n_frac",   32'hB400_0000, '{1'b1, 8'd1,   31'h6000_0000, 1'b0, 1'b0});

        // Four back-to-back words with the consumer stalled for three cycles.
        base = n_out;
        saw_stall = 0;
        fork
            begin
                send(32'h4000_0000);
                send(32'h4800_0000);
                send(32'hC000_0000);
                send(32'h0000_0001);
                in_valid = 1'b0;
            end
            begin
                t = 0;
                while (!out_valid && t < 20) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                check("bp_first_valid", 64'(out_valid), 64'(1));
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_stall_seen", 64'(saw_stall), 64'(1));
        check("bp_count", 64'(n_out - base), 64'(4));

        // One-cycle reset with two words in flight.
        send(32'h5000_0000);
        send(32'h4C00_0000);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_in_ready_after", 64'(in_ready), 64'(1));
        repeat (4) begin
            @(posedge clk);
            #1;
            check("mid_rst_no_stale", 64'(out_valid), 64'(0));
        end

        // Random traffic with random consumer backpressure.
        base = n_out;
        done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send(rand_word());
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("rand_count", 64'(n_out - base), 64'(300));
`ifdef POSIT_DECODE_STATS_EN
        check("rand_cnt_zero", 64'(cnt_zero), 64'(n_zero));
        check("rand_cnt_inf", 64'(cnt_inf), 64'(n_inf));
`endif

        // Three zeros and two NaR after a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef POSIT_DECODE_STATS_EN
        check("cnt_zero_reset", 64'(cnt_zero), 64'(0));
        check("cnt_inf_reset", 64'(cnt_inf), 64'(0));
`endif
        send(32'h0000_0000);
        send(32'h8000_0000);
        send(32'h0000_0000);
        send(32'h4000_0000);
        send(32'h8000_0000);
        send(32'h0000_0000);
        in_valid = 1'b0;
        drain();
        repeat (2) @(posedge clk);
        #1;
`ifdef POSIT_DECODE_STATS_EN
        check("cnt_zero_3", 64'(cnt_zero), 64'(3));
        check("cnt_inf_2", 64'(cnt_inf), 64'(2));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/posit_decode_stream.md
POSIT_DECODE_STREAM -- requirements
Module: posit_decode_stream

Interface
REQ-001 SHALL have parameter N, default 32, posit word width.
REQ-002 SHALL have parameter es, default 2, exponent field width.
REQ-003 SHALL have parameter Bs, default log2(N), regime-count width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  N  posit word to decode.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  decoded fields valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the output.
REQ-011 SHALL have port out_s  output  1  sign bit.
REQ-012 SHALL have port out_scale  output  Bs+es+1  signed scale, k*2^es + e.
REQ-013 SHALL have port out_mant  output  N-es+1  {hidden bit, fraction left-aligned, zero-padded}.
REQ-014 SHALL have ports out_zero and out_inf  output  1 each  input was 0x0 or NaR (sign bit only).

Function
REQ-015 SHALL accept a word when in_valid & in_ready and present it when out_valid & out_ready.
REQ-016 SHALL be a two-stage pipeline: stage A registers the word, takes the two's complement if negative and counts the regime run; stage B shifts out regime, exponent and fraction and registers the outputs.
REQ-017 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when out_ready stays high.
REQ-018 SHALL sustain one word per cycle when out_ready is continuously high.
REQ-019 SHALL drive in_ready = ~vA | ~vB | out_ready, where vA and vB are the stage-valid flags.
REQ-020 SHALL hold out_* stable while out_valid & ~out_ready, with no loss, duplication or reordering.
REQ-021 SHALL advance stage A into stage B whenever stage B is empty or is draining in the same cycle.
REQ-022 SHALL compute the regime as k = run-1 for a leading run of ones and k = -run for a leading run of zeros, with run clipped to N-1.
REQ-023 SHALL take e from the next es bits after the terminating regime bit and zero-fill exponent bits truncated by the word end.
REQ-024 SHALL set out_zero for 0x0 and out_inf for 0x80..0; for both, out_scale=0, out_mant=0, out_s=in_data[N-1].
REQ-025 SHALL set the hidden bit = ~(out_zero | out_inf), the same hidden-bit convention as the multiplier's {nonzero, frac}.
REQ-026 SHALL treat in_data containing X as zero (out_zero=1) in simulation.

Reset
REQ-027 SHALL clear vA, vB and out_valid on reset and drive out_s, out_scale, out_mant, out_zero and out_inf to 0.
REQ-028 SHALL discard words in flight when reset is asserted mid-operation and drive in_ready=0 during reset.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-030 SHALL, with POSIT_DECODE_STATS_EN defined, add output ports cnt_zero and cnt_inf (32 bits each) that count output handshakes with out_zero or out_inf set, saturate at 0xFFFFFFFF and clear on reset.
REQ-031 SHALL, without POSIT_DECODE_STATS_EN, omit those ports and counters and leave all other behaviour identical.

Verification
REQ-032 0x40000000 -> out_s=0, scale=0, mant=1 followed by zeros, 2 cycles after acceptance.
REQ-033 0x48000000 -> scale=1 and 0x50000000 -> scale=2; 0xC0000000 -> s=1, scale=0, mant hidden=1.
REQ-034 0x7FFFFFFF -> scale=120; 0x00000001 -> scale=-120; 0x00000000 -> out_zero=1; 0x80000000 -> out_inf=1, mant=0.
REQ-035 Back-to-back 4 words, out_ready low for 3 cycles after the first out_valid -> in_ready drops once both stages are full and all 4 outputs appear in order with no duplicates.
REQ-036 reset asserted for 1 cycle with 2 words in flight -> out_valid=0 the next cycle, no stale output, in_ready=1 after release.
REQ-037 With POSIT_DECODE_STATS_EN: 3 zeros and 2 NaR drained -> cnt_zero=3, cnt_inf=2.
